data_memory_responder: RTL and testbench

//  Multi-cycle data-memory target serving the core's load/store port over a req/ready handshake.

---
 rtl/data_memory_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_data_memory_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
//   Multi-cycle data-memory target for the core's load/store port. An access
//   is accepted from IDLE when req is high, waits LATENCY cycles, and
//   completes with a one-cycle ready pulse. The block handles RISC-V
//   B/H/W/BU/HU accesses with lane selection and sign/zero extension.
//
//   Optional feature macro: MISALIGN_TRAP_EN
//     defined   : misaligned or illegal accesses complete with err=1 and
//                 rdata=0, and they never write the RAM.
//     undefined : err is tied 0. Sub-alignment address bits are ignored.
//                 Illegal size codes act as W. Stores with 100/101 act as
//                 000/001.
//
// Parameters
//   DEPTH_WORDS : storage size in 32-bit words (power of two, >= 2)
//   LATENCY     : wait cycles between accept and response (0..15)
//
// Ports
//   clk   in   clock, all state changes on posedge
//   rst   in   synchronous active-high reset
//   req   in   access request, held until ready
//   we    in   1 = store, 0 = load (sampled at accept)
//   size  in   func3 size code (sampled at accept)
//   addr  in   byte address (sampled at accept)
//   wdata in   right-justified store data (sampled at accept)
//   rdata out  registered, extended load result (0 for stores and faults)
//   ready out  one-cycle completion pulse
//   busy  out  high from the cycle after accept through the ready cycle
//   err   out  access fault, valid with ready
// -----------------------------------------------------------------------------
module data_memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    localparam logic [1:0] KIND_B = 2'd0;
    localparam logic [1:0] KIND_H = 2'd1;
    localparam logic [1:0] KIND_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [3:0]        cnt_r;
    logic              we_r;
    logic [2:0]        size_r;
    logic [IDX_W+1:0]  addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       mem_r [DEPTH_WORDS];

    logic              accept_s;
    logic              enter_done_s;
    logic              op_we_s;
    logic [2:0]        op_size_s;
    logic [IDX_W+1:0]  op_addr_s;
    logic [31:0]       op_wdata_s;
    logic [1:0]        kind_s;
    logic              unsigned_s;
    logic              fault_s;
    logic [1:0]        off_s;
    logic [IDX_W-1:0]  idx_s;
    logic [31:0]       old_word_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic [3:0]        be_s;
    logic [31:0]       wlane_s;
    logic [31:0]       load_s;
    logic [31:0]       merged_s;
    logic              unused_addr_s;

    // Address bits above the storage range alias and are deliberately dropped.
    assign unused_addr_s = ^addr[31:IDX_W+2];

    assign accept_s     = (state_r == ST_IDLE) && req;
    assign enter_done_s = (state_nxt_s == ST_DONE);

    // Next-state logic for the IDLE -> WAIT -> DONE -> IDLE sequence
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    state_nxt_s = (LATENCY > 0) ? ST_WAIT : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                cnt_r <= CNT_INIT;
            end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    // Capture the request fields at accept
    always_ff @(posedge clk) begin
        if (accept_s) begin
            we_r    <= we;
            size_r  <= size;
            addr_r  <= addr[IDX_W+1:0];
            wdata_r <= wdata;
        end
    end

    // With LATENCY=0 the completing edge is the accept edge, so the live inputs are used there.
    always_comb begin
        if (state_r == ST_IDLE) begin
            op_we_s    = we;
            op_size_s  = size;
            op_addr_s  = addr[IDX_W+1:0];
            op_wdata_s = wdata;
        end else begin
            op_we_s    = we_r;
            op_size_s  = size_r;
            op_addr_s  = addr_r;
            op_wdata_s = wdata_r;
        end
    end

    // Size decode; illegal codes fall through to word width
    always_comb begin
        kind_s     = KIND_W;
        unsigned_s = 1'b0;
        case (op_size_s)
            3'b000:  begin kind_s = KIND_B; unsigned_s = 1'b0; end
            3'b001:  begin kind_s = KIND_H; unsigned_s = 1'b0; end
            3'b010:  begin kind_s = KIND_W; unsigned_s = 1'b0; end
            3'b100:  begin kind_s = KIND_B; unsigned_s = 1'b1; end
            3'b101:  begin kind_s = KIND_H; unsigned_s = 1'b1; end
            default: begin kind_s = KIND_W; unsigned_s = 1'b0; end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic illegal_s;
    logic misalign_s;
    assign illegal_s  = (op_size_s == 3'b011) || (op_size_s[2:1] == 2'b11) ||
                        (op_we_s && op_size_s[2]);
    assign misalign_s = ((kind_s == KIND_H) && op_addr_s[0]) ||
                        ((kind_s == KIND_W) && (op_addr_s[1:0] != 2'b00));
    assign fault_s    = illegal_s || misalign_s;
`else
    assign fault_s    = 1'b0;
`endif

    // Lane selection for both the load result and the store merge
    always_comb begin
        off_s      = op_addr_s[1:0];
        idx_s      = op_addr_s[IDX_W+1:2];
        old_word_s = mem_r[idx_s];
        byte_s     = old_word_s[{off_s, 3'b000} +: 8];
        half_s     = op_addr_s[1] ? old_word_s[31:16] : old_word_s[15:0];
        be_s       = 4'b1111;
        wlane_s    = op_wdata_s;
        load_s     = old_word_s;
        merged_s   = old_word_s;
        case (kind_s)
            KIND_B: begin
                be_s    = 4'b0001 << off_s;
                wlane_s = {4{op_wdata_s[7:0]}};
                load_s  = unsigned_s ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
            end
            KIND_H: begin
                be_s    = op_addr_s[1] ? 4'b1100 : 4'b0011;
                wlane_s = {2{op_wdata_s[15:0]}};
                load_s  = unsigned_s ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
            end
            default: begin
                be_s    = 4'b1111;
                wlane_s = op_wdata_s;
                load_s  = old_word_s;
            end
        endcase
        for (int b = 0; b < 4; b++) begin
            if (be_s[b]) begin
                merged_s[8*b +: 8] = wlane_s[8*b +: 8];
            end else begin
                merged_s[8*b +: 8] = old_word_s[8*b +: 8];
            end
        end
    end

    // Store commit on the edge entering DONE; faulting stores are dropped
    always_ff @(posedge clk) begin
        if (!rst && enter_done_s && op_we_s && !fault_s) begin
            mem_r[idx_s] <= merged_s;
        end
    end

    // Registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 32'd0;
            ready <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            ready <= enter_done_s;
            busy  <= (state_nxt_s != ST_IDLE);
            if (enter_done_s) begin
                err   <= fault_s;
                rdata <= (op_we_s || fault_s) ? 32'd0 : load_s;
            end else begin
                err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Reference memory: word index -> contents
    logic [31:0] mem_m [int];

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .err(err)
    );

    // Behavioural model of one access, derived from the RISC-V access rules.
    function automatic void ref_access(input logic w, input logic [2:0] s, input logic [31:0] a,
                                       input logic [31:0] d, output logic [31:0] rd,
                                       output logic e);
        int          nbytes;
        int          off;
        int          idx;
        bit          legal;
        bit          mis;
        bit          sgn;
        logic [31:0] word;
        longint      v;
        longint      full;
        legal  = (s == 0 || s == 1 || s == 2 || s == 4 || s == 5) && !(w && s >= 4);
        nbytes = (s == 0 || s == 4) ? 1 : ((s == 1 || s == 5) ? 2 : 4);
        mis    = (nbytes == 2 && (a % 2) != 0) || (nbytes == 4 && (a % 4) != 0);
        rd = 32'd0;
        e  = 1'b0;
        if (TRAP && (!legal || mis)) begin
            e = 1'b1;
            return;
        end
        sgn  = (s == 0 || s == 1);
        off  = (nbytes == 1) ? int'(a % 4) : ((nbytes == 2) ? int'((a % 4) / 2 * 2) : 0);
        idx  = int'((a / 4) % DEPTH);
        word = mem_m.exists(idx) ? mem_m[idx] : 32'd0;
        if (w) begin
            for (int i = 0; i < nbytes; i++) word[8*(off+i) +: 8] = d[8*i +: 8];
            mem_m[idx] = word;
        end else begin
            full = longint'(1) << (8 * nbytes);
            v    = (longint'(word) >> (8 * off)) % full;
            if (sgn && nbytes < 4 && v >= full / 2) v = v - full;
            rd = v[31:0];
        end
    endfunction

    // Drives one access and reports the response plus a timing verdict
    // (single ready pulse at cycle LAT+1 after accept, busy through it).
    task automatic access(input logic w, input logic [2:0] s, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic e,
                          output int rdy_n, output bit tok);
        int pulses;
        bit busy_ok;
        @(negedge clk);
        req = 1'b1; we = w; size = s; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        rdy_n = -1; pulses = 0; busy_ok = 1'b1; rd = 32'd0; e = 1'b0;
        for (int n = 1; n <= LAT + 3; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
            if (ready === 1'b1) begin
                pulses++;
                if (rdy_n < 0) begin rdy_n = n; rd = rdata; e = err; end
            end
            if (busy !== ((n <= LAT + 1) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
        end
        tok = (rdy_n == LAT + 1) && (pulses == 1) && busy_ok;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 3'b010; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_latency;
        logic [31:0] rd, erd; logic e, ee; int rn; bit tok;
        access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, e, rn, tok);
        ref_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, erd, ee);
        checks++; if (tok !== 1'b1) begin errors++; $display("FAIL sw_timing ready at %0d exp %0d (busy/pulse ok=%b)", rn, LAT + 1, tok); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL sw_rdata got %h exp 0", rd); end
        access(1'b0, 3'b010, 32'h10, 32'h0, rd, e, rn, tok);
        checks++; if (tok !== 1'b1) begin errors++; $display("FAIL lw_timing ready at %0d exp %0d", rn, LAT + 1); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", e); end
    endtask

    task automatic test_extension;
        logic [31:0] a_t [7] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h10, 32'h12};
        logic [2:0]  s_t [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b000, 3'b100};
        logic [31:0] x_t [7] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF,
                                 32'hFFFFBEEF, 32'hFFFFFFEF, 32'h000000AD};
        logic [31:0] rd; logic e; int rn; bit tok;
        for (int i = 0; i < 7; i++) begin
            access(1'b0, s_t[i], a_t[i], 32'h0, rd, e, rn, tok);
            checks++;
            if (rd !== x_t[i] || e !== 1'b0)
                begin errors++; $display("FAIL ext_load%0d got %h/%b exp %h/0", i, rd, e, x_t[i]); end
        end
    endtask

    task automatic test_lane_store;
        logic [31:0] rd, erd; logic e, ee; int rn; bit tok;
        access(1'b1, 3'b000, 32'h11, 32'h12345655, rd, e, rn, tok);
        ref_access(1'b1, 3'b000, 32'h11, 32'h12345655, erd, ee);
        access(1'b0, 3'b010, 32'h10, 32'h0, rd, e, rn, tok);
        checks++; if (rd !== 32'hDEAD55EF) begin errors++; $display("FAIL sb_merge got %h exp dead55ef", rd); end
        access(1'b1, 3'b001, 32'h12, 32'hAAAA1234, rd, e, rn, tok);
        ref_access(1'b1, 3'b001, 32'h12, 32'hAAAA1234, erd, ee);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL sh_rdata got %h exp 0", rd); end
        access(1'b0, 3'b010, 32'h10, 32'h0, rd, e, rn, tok);
        checks++; if (rd !== 32'h123455EF) begin errors++; $display("FAIL sh_merge got %h exp 123455ef", rd); end
    endtask

    task automatic test_misalign;
        logic [31:0] rd, erd, exp_rd; logic e, ee, exp_e; int rn; bit tok;
        exp_rd = TRAP ? 32'd0 : 32'h123455EF;
        exp_e  = TRAP;
        access(1'b0, 3'b010, 32'h12, 32'h0, rd, e, rn, tok);
        checks++;
        if (rd !== exp_rd || e !== exp_e || tok !== 1'b1)
            begin errors++; $display("FAIL lw_misal got %h/%b t%0d exp %h/%b t%0d", rd, e, rn, exp_rd, exp_e, LAT + 1); end
        access(1'b0, 3'b010, 32'h10, 32'h0, rd, e, rn, tok);
        checks++; if (rd !== 32'h123455EF || e !== 1'b0) begin errors++; $display("FAIL lw_after_misal got %h/%b exp 123455ef/0", rd, e); end
        // Misaligned halfword store and an illegal size code, checked against the model
        access(1'b1, 3'b001, 32'h11, 32'h00007777, rd, e, rn, tok);
        ref_access(1'b1, 3'b001, 32'h11, 32'h00007777, erd, ee);
        checks++; if (e !== ee) begin errors++; $display("FAIL sh_misal_err got %b exp %b", e, ee); end
        access(1'b0, 3'b011, 32'h10, 32'h0, rd, e, rn, tok);
        ref_access(1'b0, 3'b011, 32'h10, 32'h0, erd, ee);
        checks++; if (rd !== erd || e !== ee) begin errors++; $display("FAIL illegal_size got %h/%b exp %h/%b", rd, e, erd, ee); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd, erd; logic e, ee; int rn; bit tok; int pulses;
        access(1'b1, 3'b010, 32'h20, 32'h1, rd, e, rn, tok);
        ref_access(1'b1, 3'b010, 32'h20, 32'h1, erd, ee);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 3'b010; addr = 32'h20; wdata = 32'h2;
        @(posedge clk); #1; req = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        repeat (LAT + 3) begin @(posedge clk); #1; if (ready === 1'b1) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_ready got %0d pulses exp 0", pulses); end
        // Request asserted together with reset must not be accepted
        @(negedge clk); rst = 1'b1; req = 1'b1; wdata = 32'h3;
        @(posedge clk);
        @(negedge clk); rst = 1'b0; req = 1'b0;
        pulses = 0;
        repeat (LAT + 3) begin @(posedge clk); #1; if (ready === 1'b1 || busy === 1'b1) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_req_activity got %0d exp 0", pulses); end
        access(1'b0, 3'b010, 32'h20, 32'h0, rd, e, rn, tok);
        checks++; if (rd !== 32'h00000001) begin errors++; $display("FAIL rst_mid_data got %h exp 00000001", rd); end
    endtask

    task automatic test_alias;
        logic [31:0] rd, erd; logic e, ee; int rn; bit tok;
        access(1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, rd, e, rn, tok);
        ref_access(1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, erd, ee);
        access(1'b0, 3'b010, 32'h0, 32'h0, rd, e, rn, tok);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL alias got %h exp cafef00d", rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd1, rd2, x1, x2; logic ee; int first, second, extra;
        ref_access(1'b0, 3'b010, 32'h10, 32'h0, x1, ee);
        ref_access(1'b0, 3'b010, 32'h0, 32'h0, x2, ee);
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 3'b010; addr = 32'h10; wdata = 32'h0;
        @(posedge clk); #1;
        first = -1; second = -1; extra = 0; rd1 = 32'd0; rd2 = 32'd0;
        for (int n = 1; n <= 2 * LAT + 6; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
            if (ready === 1'b1) begin
                if (first < 0) begin first = n; rd1 = rdata; addr = 32'h0; end
                else if (second < 0) begin second = n; rd2 = rdata; req = 1'b0; end
                else extra++;
            end
        end
        req = 1'b0;
        checks++; if (first !== LAT + 1) begin errors++; $display("FAIL b2b_first got %0d exp %0d", first, LAT + 1); end
        checks++; if (second !== 2 * LAT + 3 || extra !== 0) begin errors++; $display("FAIL b2b_second got %0d (+%0d) exp %0d", second, extra, 2 * LAT + 3); end
        checks++; if (rd1 !== x1 || rd2 !== x2) begin errors++; $display("FAIL b2b_data got %h,%h exp %h,%h", rd1, rd2, x1, x2); end
    endtask

    task automatic test_random;
        logic [31:0] rd, erd, a, d; logic e, ee, w; logic [2:0] s; int rn; bit tok; int bad;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            access(1'b1, 3'b010, 32'h100 + 32'(4 * i), d, rd, e, rn, tok);
            ref_access(1'b1, 3'b010, 32'h100 + 32'(4 * i), d, erd, ee);
        end
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            w = 1'($urandom_range(0, 1));
            s = 3'($urandom_range(0, 7));
            a = ($urandom & 32'hFFFFF000) | (32'h100 + 32'($urandom_range(0, 63)));
            d = $urandom;
            access(w, s, a, d, rd, e, rn, tok);
            ref_access(w, s, a, d, erd, ee);
            checks++;
            if (rd !== erd || e !== ee || tok !== 1'b1) begin
                errors++;
                if (bad < 10) $display("FAIL rnd%0d we=%b sz=%b a=%h got %h/%b t%0d exp %h/%b t%0d",
                                       i, w, s, a, rd, e, rn, erd, ee, LAT + 1);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_extension();
        test_lane_store();
        test_misalign();
        test_reset_mid();
        test_alias();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
